fft_timer_bank: RTL and testbench

FFT_TIMER_BANK -- requirements
Module: fft_timer_bank

---
 rtl/fft_timer_pkg.sv | 20 ++
 rtl/fft_timer_bank_if.sv | 51 +++++
 rtl/fft_timer_bank_wrap_counter.sv | 44 ++++
 rtl/fft_timer_bank.sv | 100 ++++++++++
 tb/tb_fft_timer_bank.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_timer_pkg.sv
// Purpose: shared types and default sizing for the FFT frame timer bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_timer_pkg;

  // Frame phase; encoding is visible on the phase port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } phase_t;

  localparam int DEF_NUM_SAMPLES     = 8;
  localparam int DEF_LOAD_BEATS      = 6;
  localparam int DEF_ITERS_PER_STAGE = 16;
  localparam int DEF_NUM_STAGES      = 8;
  localparam int DEF_WRITE_BEATS     = 4;

endpackage

// File: rtl/fft_timer_bank_if.sv
// Purpose: control/status bundle between a frame sequencer and fft_timer_bank.
// Latency: n/a (wires only).
// Backpressure: none; enables are single-cycle beats, every beat is consumed.
// Ports: master drives start/abort/enables and observes status; slave is the timer bank.
interface fft_timer_bank_if #(
  parameter int NUM_SAMPLES     = 8,
  parameter int LOAD_BEATS      = 6,
  parameter int ITERS_PER_STAGE = 16,
  parameter int NUM_STAGES      = 8,
  parameter int WRITE_BEATS     = 4
);
  logic                               start;
  logic                               abort;
  logic                               shift_in_ena;
  logic                               iteration_ena;
  logic                               shift_out_ena;

  logic [1:0]                         phase;
  logic                               busy;
  logic [$clog2(LOAD_BEATS)-1:0]      samples_loaded_count;
  logic [$clog2(NUM_SAMPLES)-1:0]     samples_in_count;
  logic [$clog2(ITERS_PER_STAGE)-1:0] iteration_count;
  logic [$clog2(NUM_STAGES)-1:0]      stage_count;
  logic [$clog2(WRITE_BEATS)-1:0]     samples_written_count;
  logic [$clog2(NUM_SAMPLES)-1:0]     samples_out_count;
  logic                               samples_loaded_done;
  logic                               samples_in_done;
  logic                               iteration_done;
  logic                               fft_done;
  logic                               samples_written_done;
  logic                               samples_out_done;
  logic                               frame_done;
  logic                               overrun_err;

  modport master (
    output start, abort, shift_in_ena, iteration_ena, shift_out_ena,
    input  phase, busy, samples_loaded_count, samples_in_count, iteration_count,
           stage_count, samples_written_count, samples_out_count,
           samples_loaded_done, samples_in_done, iteration_done, fft_done,
           samples_written_done, samples_out_done, frame_done, overrun_err
  );

  modport slave (
    input  start, abort, shift_in_ena, iteration_ena, shift_out_ena,
    output phase, busy, samples_loaded_count, samples_in_count, iteration_count,
           stage_count, samples_written_count, samples_out_count,
           samples_loaded_done, samples_in_done, iteration_done, fft_done,
           samples_written_done, samples_out_done, frame_done, overrun_err
  );

endinterface

// File: rtl/fft_timer_bank_wrap_counter.sv
// Purpose: mod-N beat counter with synchronous clear and registered wrap pulse.
// Latency: count updates on the enabling edge; wrap pulse is high the cycle after the wrapping beat.
// Backpressure: none; a beat is counted on every cycle en is high.
// Ports: en/clr in; cnt_o count, last_o combinational "this beat wraps" for cascading, wrap_o pulse.
module wrap_counter #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt_o,
  output logic         last_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q;

  // Clear wins so an aborted beat never cascades into the next counter.
  assign last_o = en & ~clr & (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)         cnt_d = '0;
    else if (last_o) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= last_o;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/fft_timer_bank.sv
// Purpose: load/compute/unload phase sequencer for one FFT frame built from six cascaded wrap counters.
// Latency: phase and counts change on the consuming edge; done pulses appear the following cycle.
// Backpressure: none; out-of-phase enables are dropped (flagged on overrun_err when FFT_TIMER_OVERRUN_EN is defined).
// Ports: clk, n_rst (async active-low), bus (fft_timer_bank_if.slave) carrying controls and status.
module fft_timer_bank
  import fft_timer_pkg::*;
#(
  parameter int NUM_SAMPLES     = DEF_NUM_SAMPLES,
  parameter int LOAD_BEATS      = DEF_LOAD_BEATS,
  parameter int ITERS_PER_STAGE = DEF_ITERS_PER_STAGE,
  parameter int NUM_STAGES      = DEF_NUM_STAGES,
  parameter int WRITE_BEATS     = DEF_WRITE_BEATS
) (
  input  logic              clk,
  input  logic              n_rst,
  fft_timer_bank_if.slave   bus
);

  phase_t phase_q, phase_d;
  logic   frame_done_q;
  logic   ld_en, in_en, it_en, st_en, wb_en, out_en;
  logic   ld_last, in_last, it_last, st_last, wb_last, out_last;

  // Each counter only sees its enable in its own phase; abort kills the beat.
  assign ld_en  = (phase_q == LOAD)    & bus.shift_in_ena  & ~bus.abort;
  assign in_en  = ld_last;
  assign it_en  = (phase_q == COMPUTE) & bus.iteration_ena & ~bus.abort;
  assign st_en  = it_last;
  assign wb_en  = (phase_q == UNLOAD)  & bus.shift_out_ena & ~bus.abort;
  assign out_en = wb_last;

  wrap_counter #(.N(LOAD_BEATS)) u_ld_cnt (
    .clk(clk), .n_rst(n_rst), .en(ld_en), .clr(bus.abort),
    .cnt_o(bus.samples_loaded_count), .last_o(ld_last), .wrap_o(bus.samples_loaded_done));
  wrap_counter #(.N(NUM_SAMPLES)) u_in_cnt (
    .clk(clk), .n_rst(n_rst), .en(in_en), .clr(bus.abort),
    .cnt_o(bus.samples_in_count), .last_o(in_last), .wrap_o(bus.samples_in_done));
  wrap_counter #(.N(ITERS_PER_STAGE)) u_it_cnt (
    .clk(clk), .n_rst(n_rst), .en(it_en), .clr(bus.abort),
    .cnt_o(bus.iteration_count), .last_o(it_last), .wrap_o(bus.iteration_done));
  wrap_counter #(.N(NUM_STAGES)) u_st_cnt (
    .clk(clk), .n_rst(n_rst), .en(st_en), .clr(bus.abort),
    .cnt_o(bus.stage_count), .last_o(st_last), .wrap_o(bus.fft_done));
  wrap_counter #(.N(WRITE_BEATS)) u_wb_cnt (
    .clk(clk), .n_rst(n_rst), .en(wb_en), .clr(bus.abort),
    .cnt_o(bus.samples_written_count), .last_o(wb_last), .wrap_o(bus.samples_written_done));
  wrap_counter #(.N(NUM_SAMPLES)) u_out_cnt (
    .clk(clk), .n_rst(n_rst), .en(out_en), .clr(bus.abort),
    .cnt_o(bus.samples_out_count), .last_o(out_last), .wrap_o(bus.samples_out_done));

  always_comb begin
    phase_d = phase_q;
    if (bus.abort) begin
      phase_d = IDLE;
    end else begin
      case (phase_q)
        IDLE:    if (bus.start) phase_d = LOAD;
        LOAD:    if (in_last)   phase_d = COMPUTE;
        COMPUTE: if (st_last)   phase_d = UNLOAD;
        UNLOAD:  if (out_last)  phase_d = IDLE;
        default:                phase_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      frame_done_q <= out_last;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.busy       = (phase_q != IDLE);
  assign bus.frame_done = frame_done_q;

`ifdef FFT_TIMER_OVERRUN_EN
  logic err_q, err_set, err_clr;

  assign err_set = (bus.shift_in_ena  & (phase_q != LOAD))
                 | (bus.iteration_ena & (phase_q != COMPUTE))
                 | (bus.shift_out_ena & (phase_q != UNLOAD))
                 | (bus.start         & (phase_q != IDLE));
  assign err_clr = bus.abort | (bus.start & (phase_q == IDLE));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       err_q <= 1'b0;
    else if (err_clr) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign bus.overrun_err = err_q;
`else
  assign bus.overrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_timer_bank.sv
// Purpose: self-checking bench for fft_timer_bank against a beat-count reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fft_timer_bank;
  import fft_timer_pkg::*;

  localparam int NS = 8, LB = 6, IPS = 16, NST = 8, WB = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fft_timer_bank_if #(.NUM_SAMPLES(NS), .LOAD_BEATS(LB), .ITERS_PER_STAGE(IPS),
                      .NUM_STAGES(NST), .WRITE_BEATS(WB)) bus0 ();
  fft_timer_bank_if #(.NUM_SAMPLES(16), .LOAD_BEATS(3), .ITERS_PER_STAGE(4),
                      .NUM_STAGES(4), .WRITE_BEATS(2)) bus1 ();

  fft_timer_bank #(.NUM_SAMPLES(NS), .LOAD_BEATS(LB), .ITERS_PER_STAGE(IPS),
                   .NUM_STAGES(NST), .WRITE_BEATS(WB)) u_dut (
    .clk(clk), .n_rst(n_rst), .bus(bus0));

  fft_timer_bank #(.NUM_SAMPLES(16), .LOAD_BEATS(3), .ITERS_PER_STAGE(4),
                   .NUM_STAGES(4), .WRITE_BEATS(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the phase plus the number of beats consumed in that phase.
  // Every count is derived from the beat total by division/modulo.
  int       m_phase = 0;
  int       m_beats = 0;
  bit [6:0] m_pulse = '0;   // 6 ld,5 in,4 iter,3 fft,2 wr,1 out,0 frame
  bit       m_err   = 1'b0;
  int       tally[7];

  task automatic model_reset();
    m_phase = 0; m_beats = 0; m_pulse = '0; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit si, input bit it, input bit so);
    int ph;
    ph = m_phase;
    m_pulse = '0;
`ifdef FFT_TIMER_OVERRUN_EN
    if (ab || (st && ph == 0)) m_err = 1'b0;
    else if ((si && ph != 1) || (it && ph != 2) || (so && ph != 3) || (st && ph != 0)) m_err = 1'b1;
`endif
    if (ab) begin
      m_phase = 0; m_beats = 0;
    end else begin
      case (ph)
        0: if (st) begin m_phase = 1; m_beats = 0; end
        1: if (si) begin
             m_beats++;
             if (m_beats % LB == 0) m_pulse[6] = 1'b1;
             if (m_beats == LB * NS) begin m_pulse[5] = 1'b1; m_phase = 2; m_beats = 0; end
           end
        2: if (it) begin
             m_beats++;
             if (m_beats % IPS == 0) m_pulse[4] = 1'b1;
             if (m_beats == IPS * NST) begin m_pulse[3] = 1'b1; m_phase = 3; m_beats = 0; end
           end
        default: if (so) begin
             m_beats++;
             if (m_beats % WB == 0) m_pulse[2] = 1'b1;
             if (m_beats == WB * NS) begin
               m_pulse[1] = 1'b1; m_pulse[0] = 1'b1; m_phase = 0; m_beats = 0;
             end
           end
      endcase
    end
  endtask

  function automatic logic [47:0] model_counts();
    int ld, in, itc, stc, wr, out;
    ld = 0; in = 0; itc = 0; stc = 0; wr = 0; out = 0;
    if (m_phase == 1) begin ld = m_beats % LB;  in  = m_beats / LB;  end
    if (m_phase == 2) begin itc = m_beats % IPS; stc = m_beats / IPS; end
    if (m_phase == 3) begin wr = m_beats % WB;  out = m_beats / WB;  end
    return {8'(ld), 8'(in), 8'(itc), 8'(stc), 8'(wr), 8'(out)};
  endfunction

  function automatic logic [47:0] dut_counts();
    return {8'(bus0.samples_loaded_count), 8'(bus0.samples_in_count),
            8'(bus0.iteration_count), 8'(bus0.stage_count),
            8'(bus0.samples_written_count), 8'(bus0.samples_out_count)};
  endfunction

  function automatic logic [6:0] dut_pulses();
    return {bus0.samples_loaded_done, bus0.samples_in_done, bus0.iteration_done,
            bus0.fft_done, bus0.samples_written_done, bus0.samples_out_done,
            bus0.frame_done};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/phase"},  64'(bus0.phase), 64'(m_phase));
    chk({tag, "/busy"},   64'(bus0.busy), 64'(m_phase != 0));
    chk({tag, "/counts"}, 64'(dut_counts()), 64'(model_counts()));
    chk({tag, "/pulses"}, 64'(dut_pulses()), 64'(m_pulse));
    chk({tag, "/err"},    64'(bus0.overrun_err), 64'(m_err));
  endtask

  task automatic step(input string tag, input bit st, input bit ab,
                      input bit si, input bit it, input bit so);
    logic [6:0] p;
    bus0.start = st; bus0.abort = ab;
    bus0.shift_in_ena = si; bus0.iteration_ena = it; bus0.shift_out_ena = so;
    @(posedge clk);
    model_edge(st, ab, si, it, so);
    #1;
    p = dut_pulses();
    for (int i = 0; i < 7; i++) tally[i] += int'(p[i]);
    check_all(tag);
  endtask

  task automatic clear_tally();
    for (int i = 0; i < 7; i++) tally[i] = 0;
  endtask

  task automatic check_tally(input string tag);
    chk({tag, "/n_ld_done"},  64'(tally[6]), 64'(NS));
    chk({tag, "/n_in_done"},  64'(tally[5]), 64'(1));
    chk({tag, "/n_it_done"},  64'(tally[4]), 64'(NST));
    chk({tag, "/n_fft_done"}, 64'(tally[3]), 64'(1));
    chk({tag, "/n_wr_done"},  64'(tally[2]), 64'(NS));
    chk({tag, "/n_out_done"}, 64'(tally[1]), 64'(1));
    chk({tag, "/n_frame"},    64'(tally[0]), 64'(1));
  endtask

  task automatic full_frame(input string tag);
    clear_tally();
    step(tag, 1, 0, 0, 0, 0);
    repeat (LB * NS)   step(tag, 0, 0, 1, 0, 0);
    repeat (IPS * NST) step(tag, 0, 0, 0, 1, 0);
    repeat (WB * NS)   step(tag, 0, 0, 0, 0, 1);
    chk({tag, "/frame_done_after_last"}, 64'(bus0.frame_done), 64'(1));
    check_tally(tag);
  endtask

  task automatic step2(input bit st, input bit si, input bit it, input bit so);
    bus1.start = st; bus1.shift_in_ena = si; bus1.iteration_ena = it; bus1.shift_out_ena = so;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit st, si, it, so, ab;
    int guard;
    bus0.start = 0; bus0.abort = 0; bus0.shift_in_ena = 0;
    bus0.iteration_ena = 0; bus0.shift_out_ena = 0;
    bus1.start = 0; bus1.abort = 0; bus1.shift_in_ena = 0;
    bus1.iteration_ena = 0; bus1.shift_out_ena = 0;
    model_reset();
    clear_tally();

    // Reset state while n_rst is held low.
    #12;
    check_all("reset");
    @(negedge clk) n_rst = 1'b1;

    // Back-to-back full frame; start accepted on the first edge after release.
    full_frame("frame_b2b");

    // Abort mid-load together with a load beat.
    step("abort_setup", 1, 0, 0, 0, 0);
    repeat (3 * LB + 2) step("abort_setup", 0, 0, 1, 0, 0);
    chk("abort_pre_in", 64'(bus0.samples_in_count), 64'(3));
    chk("abort_pre_ld", 64'(bus0.samples_loaded_count), 64'(2));
    step("abort", 0, 1, 1, 0, 0);
    chk("abort_phase", 64'(bus0.phase), 64'(0));

    // Foreign enables held during COMPUTE.
    step("foreign_setup", 1, 0, 0, 0, 0);
    repeat (LB * NS) step("foreign_setup", 0, 0, 1, 0, 0);
    repeat (3) step("foreign_setup", 0, 0, 0, 1, 0);
    repeat (20) step("foreign", 0, 0, 1, 0, 1);
    chk("foreign_iter", 64'(bus0.iteration_count), 64'(3));
`ifdef FFT_TIMER_OVERRUN_EN
    chk("foreign_err", 64'(bus0.overrun_err), 64'(1));
`else
    chk("foreign_err", 64'(bus0.overrun_err), 64'(0));
`endif
    step("foreign_start", 1, 0, 0, 0, 0);
    step("foreign_abort", 0, 1, 0, 0, 0);

    // Random 30% duty enables through one full frame.
    clear_tally();
    step("rand_frame", 1, 0, 0, 0, 0);
    guard = 0;
    while (m_phase != 0 && guard < 5000) begin
      si = ($urandom_range(0, 9) < 3);
      it = ($urandom_range(0, 9) < 3);
      so = ($urandom_range(0, 9) < 3);
      st = ($urandom_range(0, 9) < 3);
      step("rand_frame", st, 0, si, it, so);
      guard++;
    end
    chk("rand_frame_end", 64'(bus0.phase), 64'(0));
    check_tally("rand_frame");

    // Random traffic with occasional aborts and starts.
    repeat (400) begin
      st = ($urandom_range(0, 9) < 3);
      ab = ($urandom_range(0, 99) < 2);
      si = ($urandom_range(0, 9) < 5);
      it = ($urandom_range(0, 9) < 5);
      so = ($urandom_range(0, 9) < 5);
      step("rand_abort", st, ab, si, it, so);
    end
    step("rand_abort_end", 0, 1, 0, 0, 0);

    // Asynchronous reset mid-unload.
    step("rst_setup", 1, 0, 0, 0, 0);
    repeat (LB * NS)   step("rst_setup", 0, 0, 1, 0, 0);
    repeat (IPS * NST) step("rst_setup", 0, 0, 0, 1, 0);
    repeat (5 * WB)    step("rst_setup", 0, 0, 0, 0, 1);
    chk("rst_pre_out", 64'(bus0.samples_out_count), 64'(5));
    bus0.shift_out_ena = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk) n_rst = 1'b1;
    full_frame("frame_after_rst");

    // Alternate sizing on the second instance.
    step2(1, 0, 0, 0);
    repeat (47) step2(0, 1, 0, 0);
    chk("p2_load_47", 64'(bus1.phase), 64'(1));
    step2(0, 1, 0, 0);
    chk("p2_load_48", 64'(bus1.phase), 64'(2));
    repeat (15) step2(0, 0, 1, 0);
    chk("p2_comp_15", 64'(bus1.phase), 64'(2));
    step2(0, 0, 1, 0);
    chk("p2_comp_16", 64'(bus1.phase), 64'(3));
    repeat (31) step2(0, 0, 0, 1);
    chk("p2_unl_31", 64'(bus1.phase), 64'(3));
    chk("p2_frame_31", 64'(bus1.frame_done), 64'(0));
    step2(0, 0, 0, 1);
    chk("p2_unl_32", 64'(bus1.phase), 64'(0));
    chk("p2_frame_32", 64'(bus1.frame_done), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
